// File: rtl/vga_pixel_scheduler.sv
// Round-robin arbiter that time-shares one combinational vga_pixels converter
// between two vertex requesters, forwarding good pixels and counting drops.
module vga_pixel_scheduler #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Req0Valid,
  input  logic             i_Req1Valid,
  input  logic [15:0]      i_Req0X,
  input  logic [15:0]      i_Req0Y,
  input  logic [15:0]      i_Req1X,
  input  logic [15:0]      i_Req1Y,
  output logic             o_Req0Ready,
  output logic             o_Req1Ready,
  output logic [15:0]      o_ConvX,
  output logic [15:0]      o_ConvY,
  input  logic [16:0]      i_ConvPixX,
  input  logic [16:0]      i_ConvPixY,
  input  logic             i_ConvValid,
  input  logic             i_ConvException,
  output logic             o_PixValid,
  output logic [16:0]      o_PixX,
  output logic [16:0]      o_PixY,
  output logic             o_PixSrc,
  input  logic             i_PixReady,
  output logic             o_Busy,
  output logic [CNT_W-1:0] o_DropCount,
  output logic             o_LastDropExc
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] CNT_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUTPUT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          rr;
  logic          grant;
  logic          accept;
  logic          sample;
  logic          keep;
  logic          src_q;
  logic [SW-1:0] cnt;

  // With a single valid requester it wins outright; rr only breaks ties.
  always_comb begin
    grant = rr;
    if (i_Req0Valid && !i_Req1Valid)      grant = 1'b0;
    else if (i_Req1Valid && !i_Req0Valid) grant = 1'b1;
  end

  assign o_Req0Ready = (state == IDLE) && i_Req0Valid && !grant;
  assign o_Req1Ready = (state == IDLE) && i_Req1Valid && grant;
  assign accept      = o_Req0Ready || o_Req1Ready;
  assign sample      = (state == SETTLE) && (cnt == CNT_LAST);
  assign keep        = i_ConvValid && !i_ConvException;

  assign o_PixValid  = (state == OUTPUT);
  assign o_Busy      = (state != IDLE);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETTLE;
      SETTLE:  if (sample) state_nx = keep ? OUTPUT : IDLE;
      OUTPUT:  if (i_PixReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_ConvX       <= '0;
      o_ConvY       <= '0;
      src_q         <= 1'b0;
      rr            <= 1'b0;
      cnt           <= '0;
      o_PixX        <= '0;
      o_PixY        <= '0;
      o_PixSrc      <= 1'b0;
      o_DropCount   <= '0;
      o_LastDropExc <= 1'b0;
    end else begin
      if (accept) begin
        o_ConvX <= grant ? i_Req1X : i_Req0X;
        o_ConvY <= grant ? i_Req1Y : i_Req0Y;
        src_q   <= grant;
        rr      <= ~grant;
        cnt     <= '0;
      end
      if (state == SETTLE) begin
        if (sample) begin
          if (keep) begin
            o_PixX   <= i_ConvPixX;
            o_PixY   <= i_ConvPixY;
            o_PixSrc <= src_q;
          end else begin
            if (o_DropCount != '1) o_DropCount <= o_DropCount + 1'b1;
            o_LastDropExc <= i_ConvException;
          end
        end else begin
          cnt <= cnt + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_scheduler.sv
// Directed bench: table of single-vertex transactions plus hand sequences
// for arbitration, backpressure, drop saturation and mid-flight reset.
module tb_vga_pixel_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0v = 1'b0, r1v = 1'b0;
  logic [15:0] r0x = '0, r0y = '0, r1x = '0, r1y = '0;
  logic        pix_ready = 1'b1;
  logic        force_exc = 1'b0, force_inval = 1'b0;

  logic        rdy0, rdy1, pv, psrc, busy, last_exc;
  logic [15:0] conv_x, conv_y;
  logic [16:0] pix_x, pix_y;
  logic [7:0]  drop;

  logic        b_rdy0, b_rdy1, b_pv, b_psrc, b_busy, b_last_exc;
  logic [15:0] b_conv_x, b_conv_y;
  logic [16:0] b_pix_x, b_pix_y;
  logic [1:0]  b_drop;

  logic [16:0] conv_pix_x, conv_pix_y;
  logic        conv_valid, conv_exc;

  // Stand-in converter: pixel = operand + 64, status forced by the bench.
  assign conv_pix_x = {1'b0, conv_x} + 17'd64;
  assign conv_pix_y = {1'b0, conv_y} + 17'd64;
  assign conv_valid = !force_inval;
  assign conv_exc   = force_exc;

  always #5 clk = ~clk;

  vga_pixel_scheduler #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Req0Valid(r0v), .i_Req1Valid(r1v),
    .i_Req0X(r0x), .i_Req0Y(r0y), .i_Req1X(r1x), .i_Req1Y(r1y),
    .o_Req0Ready(rdy0), .o_Req1Ready(rdy1),
    .o_ConvX(conv_x), .o_ConvY(conv_y),
    .i_ConvPixX(conv_pix_x), .i_ConvPixY(conv_pix_y),
    .i_ConvValid(conv_valid), .i_ConvException(conv_exc),
    .o_PixValid(pv), .o_PixX(pix_x), .o_PixY(pix_y), .o_PixSrc(psrc),
    .i_PixReady(pix_ready), .o_Busy(busy),
    .o_DropCount(drop), .o_LastDropExc(last_exc)
  );

  vga_pixel_scheduler #(.SETTLE_CYCLES(2), .CNT_W(2)) dut2 (
    .i_Clk(clk), .i_Reset(rst),
    .i_Req0Valid(r0v), .i_Req1Valid(r1v),
    .i_Req0X(r0x), .i_Req0Y(r0y), .i_Req1X(r1x), .i_Req1Y(r1y),
    .o_Req0Ready(b_rdy0), .o_Req1Ready(b_rdy1),
    .o_ConvX(b_conv_x), .o_ConvY(b_conv_y),
    .i_ConvPixX(conv_pix_x), .i_ConvPixY(conv_pix_y),
    .i_ConvValid(conv_valid), .i_ConvException(conv_exc),
    .o_PixValid(b_pv), .o_PixX(b_pix_x), .o_PixY(b_pix_y), .o_PixSrc(b_psrc),
    .i_PixReady(pix_ready), .o_Busy(b_busy),
    .o_DropCount(b_drop), .o_LastDropExc(b_last_exc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r0v = 1'b0; r1v = 1'b0;
    force_exc = 1'b0; force_inval = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge just after the accept edge (E0 + half a cycle).
  task automatic send(input bit src, input logic [15:0] x, input logic [15:0] y);
    int n;
    @(negedge clk);
    if (src) begin r1v = 1'b1; r1x = x; r1y = y; end
    else     begin r0v = 1'b1; r0x = x; r0y = y; end
    #1;
    n = 0;
    while (!(src ? rdy1 : rdy0) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (src) r1v = 1'b0;
    else     r0v = 1'b0;
  endtask

  typedef struct {
    bit          src;
    logic [15:0] x, y;
    bit          exc, inval;
    bit          exp_valid;
    logic [16:0] exp_x, exp_y;
    int          exp_drop;
    bit          exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 17'h00040, 17'h00040, 0, 1'b0};
    vecs[1] = '{1'b1, 16'h3C00, 16'h4000, 1'b0, 1'b0, 1'b1, 17'h03C40, 17'h04040, 0, 1'b0};
    vecs[2] = '{1'b0, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 17'h0,     17'h0,     1, 1'b1};
    vecs[3] = '{1'b1, 16'h3333, 16'h4444, 1'b0, 1'b1, 1'b0, 17'h0,     17'h0,     2, 1'b0};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h0010, 1'b0, 1'b0, 1'b1, 17'h1003F, 17'h00050, 2, 1'b0};
    vecs[5] = '{1'b0, 16'h7C00, 16'h0001, 1'b1, 1'b1, 1'b0, 17'h0,     17'h0,     3, 1'b1};

    do_reset();
    #1;
    chk("rst_rdy",      32'({rdy0, rdy1}), 32'd0);
    chk("rst_conv",     32'({conv_x, conv_y}), 32'd0);
    chk("rst_pv",       32'(pv), 32'd0);
    chk("rst_pix_x",    32'(pix_x), 32'd0);
    chk("rst_pix_y",    32'(pix_y), 32'd0);
    chk("rst_src",      32'(psrc), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_drop",     32'(drop), 32'd0);
    chk("rst_last_exc", 32'(last_exc), 32'd0);

    pix_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      force_exc   = vecs[i].exc;
      force_inval = vecs[i].inval;
      send(vecs[i].src, vecs[i].x, vecs[i].y);
      chk("tbl_conv_x", 32'(conv_x), 32'(vecs[i].x));
      chk("tbl_conv_y", 32'(conv_y), 32'(vecs[i].y));
      @(negedge clk);
      chk("tbl_settle", 32'({pv, busy}), 32'b01);
      @(negedge clk);
      chk("tbl_pv", 32'(pv), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk("tbl_pix_x", 32'(pix_x), 32'(vecs[i].exp_x));
        chk("tbl_pix_y", 32'(pix_y), 32'(vecs[i].exp_y));
        chk("tbl_src",   32'(psrc),  32'(vecs[i].src));
      end
      chk("tbl_drop",     32'(drop), 32'(vecs[i].exp_drop));
      chk("tbl_drop_w2",  32'(b_drop), 32'(vecs[i].exp_drop > 3 ? 3 : vecs[i].exp_drop));
      chk("tbl_last_exc", 32'(last_exc), 32'(vecs[i].exp_last));
      @(negedge clk);
      chk("tbl_idle", 32'({pv, busy}), 32'b00);
    end

    // Round-robin with both requesters continuously valid.
    do_reset();
    pix_ready = 1'b1;
    r0x = 16'h0100; r0y = 16'h0101; r1x = 16'h0200; r1y = 16'h0201;
    @(negedge clk);
    r0v = 1'b1; r1v = 1'b1;
    begin
      int cyc = 0, nacc = 0, last_cyc = 0;
      bit exp_src = 1'b0;
      while (nacc < 6 && cyc < 100) begin
        #1;
        if (rdy0 || rdy1) begin
          chk("alt_src", 32'({rdy0, rdy1}), exp_src ? 32'b01 : 32'b10);
          if (nacc > 0) chk("alt_gap", 32'(cyc - last_cyc), 32'd4);
          last_cyc = cyc;
          exp_src  = ~exp_src;
          nacc++;
        end
        @(negedge clk);
        cyc++;
      end
      chk("alt_count", 32'(nacc), 32'd6);
    end
    r0v = 1'b0; r1v = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure in OUTPUT with requester 1 waiting.
    do_reset();
    pix_ready = 1'b0;
    send(1'b0, 16'h1234, 16'h0042);
    r1x = 16'h5555; r1y = 16'h0AAA; r1v = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_src", 32'(psrc), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_pix_x", 32'(pix_x), 32'h1274);
      chk("bp_pix_y", 32'(pix_y), 32'h0082);
      chk("bp_pv_rdy1", 32'({pv, rdy1}), 32'b10);
      @(negedge clk);
    end
    pix_ready = 1'b1;
    #1;
    chk("bp_rdy1_before", 32'(rdy1), 32'd0);
    @(negedge clk); #1;
    chk("bp_rdy1_after", 32'({pv, rdy1}), 32'b01);
    @(posedge clk);
    @(negedge clk);
    r1v = 1'b0;
    chk("bp_conv_x", 32'(conv_x), 32'h5555);
    chk("bp_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);

    // Consecutive drops: 8-bit counter keeps counting, 2-bit one saturates.
    do_reset();
    force_exc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'(i % 2), 16'(i), 16'(i));
      repeat (2) @(negedge clk);
      chk("sat_pv", 32'(pv), 32'd0);
      chk("sat_drop_w2", 32'(b_drop), 32'(i + 1 > 3 ? 3 : i + 1));
    end
    chk("sat_drop_w8", 32'(drop), 32'd5);
    chk("sat_last_exc", 32'(last_exc), 32'd1);

    // Reset during SETTLE: vertex lost, no drop counted.
    do_reset();
    force_exc = 1'b1;
    send(1'b0, 16'h0001, 16'h0001);
    chk("rs_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_conv", 32'({conv_x, conv_y}), 32'd0);
    chk("rs_rdy", 32'({rdy0, rdy1, pv}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_drop", 32'({drop, last_exc}), 32'd0);

    // Reset during OUTPUT: pixel valid falls at once, rr back to requester 0.
    force_exc = 1'b0;
    pix_ready = 1'b0;
    send(1'b0, 16'h0010, 16'h0020);
    repeat (2) @(negedge clk);
    chk("ro_pv_pre", 32'(pv), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ro_pv", 32'(pv), 32'd0);
    chk("ro_pix", 32'({pix_x, psrc}), 32'd0);
    chk("ro_busy_drop", 32'({busy, drop}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    r0v = 1'b1; r1v = 1'b1;
    #1;
    chk("ro_grant", 32'({rdy0, rdy1}), 32'b10);
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    pix_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_scheduler.md
# vga_pixel_scheduler

Shares one `vga_pixels` coordinate converter between two vertex requesters. The two requesters are the geometry pipeline and the host/test-pattern port. The block arbitrates round-robin between them and holds the selected half-precision X/Y operands stable on the converter for a fixed settle time. It then samples the converter's pixel result and either forwards it to the framebuffer writer over a valid/ready handshake or drops it and counts the drop.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles the operands are held on the combinational converter before sampling; legal range ≥1.
- `CNT_W`, default 8: width of the drop counter.

Ports:
- `i_Clk`  in  1  the block's only clock; all state is clocked on its rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Req0Valid`, `i_Req1Valid`  in  1  requester 0/1 holds a vertex.
- `i_Req0X`, `i_Req0Y`, `i_Req1X`, `i_Req1Y`  in  16  IEEE-754 half-precision coordinates.
- `o_Req0Ready`, `o_Req1Ready`  out  1  vertex accepted when valid and ready are both high on a clock edge.
- `o_ConvX`, `o_ConvY`  out  16  registered operands driven to the converter.
- `i_ConvPixX`, `i_ConvPixY`  in  17  converter pixel outputs.
- `i_ConvValid`, `i_ConvException`  in  1  converter status.
- `o_PixValid`  out  1  pixel result available.
- `o_PixX`, `o_PixY`  out  17  registered pixel coordinates.
- `o_PixSrc`  out  1  requester index of the current pixel.
- `i_PixReady`  in  1  framebuffer writer accepts the pixel.
- `o_Busy`  out  1  high whenever the state is not IDLE.
- `o_DropCount`  out  `CNT_W`  saturating count of dropped vertices.
- `o_LastDropExc`  out  1  set to 1 if the most recent drop was caused by an exception, 0 if caused by an out-of-range result.

## Operation
- States are IDLE, SETTLE, OUTPUT.
- **IDLE: grant selection.**
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester selected by the round-robin pointer `rr` is granted.
  - `o_ReqNReady` = (state == IDLE) && (grant == N). Ready never depends on `i_PixReady`.
- **IDLE: on handshake.**
  - Register X/Y into `o_ConvX`/`o_ConvY` and the source index.
  - Set `rr` to the non-granted requester.
  - Clear the settle counter and go to SETTLE.
- **SETTLE.**
  - Operands stay constant; the counter increments each cycle.
  - On the edge that completes `SETTLE_CYCLES` cycles in SETTLE, sample the converter.
  - If `i_ConvValid` && !`i_ConvException`: load `o_PixX`/`o_PixY` from `i_ConvPixX`/`i_ConvPixY`, load `o_PixSrc`, and go to OUTPUT.
  - Otherwise (drop): increment `o_DropCount` (it holds at all-ones), set `o_LastDropExc` = `i_ConvException`, and go to IDLE.
- **OUTPUT.**
  - `o_PixValid` = 1; `o_PixX`, `o_PixY` and `o_PixSrc` are held stable.
  - Return to IDLE on the edge where `i_PixReady` is 1. Any backpressure duration is allowed.
- **Operand hold.** `o_ConvX`/`o_ConvY` keep their last value in IDLE and OUTPUT; they only change on an accept.
- **Simultaneous events.**
  - A requester dropping valid in IDLE while not granted has no effect.
  - A new request arriving during SETTLE or OUTPUT waits; ready stays low.

## Timing
- **Reset values.** All outputs 0, `rr` = 0, state IDLE, counter 0.
  - Reset mid-operation discards the in-flight vertex without counting it.
  - `o_PixValid` falls asynchronously with `i_Reset`.
- **Accept edge E0.** Operands appear on `o_ConvX`/`o_ConvY` after E0.
  - The sample occurs on edge E0+`SETTLE_CYCLES`.
  - `o_PixValid` rises after that edge.
  - Latency from accept to valid output = `SETTLE_CYCLES` cycles.
- **Throughput.** With `i_PixReady` tied to 1, at most one accept every `SETTLE_CYCLES`+2 cycles (SETTLE, 1-cycle OUTPUT, 1-cycle IDLE).
- **Drop path.** No OUTPUT cycle; the next accept can happen `SETTLE_CYCLES`+1 cycles after the previous one.
- **Counter update.** `o_DropCount` and `o_LastDropExc` update on the sample edge.

## Test plan
- Reset, then requester 0 sends X=0x0000, Y=0x0000 with the converter model returning (64,64), valid → `o_PixValid` high 2 cycles after accept with `o_PixX`=64, `o_PixY`=64, `o_PixSrc`=0; `o_DropCount`=0.
- Both requesters valid continuously for 6 vertices → grants alternate 0,1,0,1,0,1 starting at requester 0; each accept is exactly 4 cycles apart with `i_PixReady`=1.
- Converter model forces `i_ConvException`=1 on the 2nd vertex and `i_ConvValid`=0 on the 3rd → no `o_PixValid` for either; `o_DropCount`=2; `o_LastDropExc`=0 after the 3rd.
- Hold `i_PixReady`=0 for 10 cycles while in OUTPUT, with requester 1 valid → `o_PixX`/`o_PixY` are stable, `o_Req1Ready` stays 0, and the accept occurs in the cycle after the `i_PixReady`=1 edge.
- With `CNT_W`=2, force 5 consecutive drops → `o_DropCount` saturates at 3.
- Assert `i_Reset` during SETTLE and again during OUTPUT → all outputs 0 immediately, the vertex is lost and not counted, and the next grant goes to requester 0.
